// File: rtl/ist_sched.sv
// Ray/triangle intersection scheduler: walks a triangle range, drives one ist unit and keeps the closest hit.
// Optional build macro IST_SCHED_ANY_HIT_EN adds an any_hit request input that stops at the first reported hit.
module ist_sched #(
   parameter int unsigned IDX_W = 16,
   parameter int unsigned TRI_W = 384
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             req_valid,
   output logic             req_ready,
`ifdef IST_SCHED_ANY_HIT_EN
   input  logic             any_hit,
`endif
   input  logic [31:0]      origin_x,
   input  logic [31:0]      origin_y,
   input  logic [31:0]      origin_z,
   input  logic [31:0]      dir_x,
   input  logic [31:0]      dir_y,
   input  logic [31:0]      dir_z,
   input  logic [31:0]      tmax,
   input  logic [IDX_W-1:0] tri_first,
   input  logic [IDX_W-1:0] tri_count,
   output logic             tri_rd_en,
   output logic [IDX_W-1:0] tri_addr,
   input  logic [TRI_W-1:0] tri_rdata,
   output logic             ist_valid,
   output logic [31:0]      ist_origin_x,
   output logic [31:0]      ist_origin_y,
   output logic [31:0]      ist_origin_z,
   output logic [31:0]      ist_dir_x,
   output logic [31:0]      ist_dir_y,
   output logic [31:0]      ist_dir_z,
   output logic [31:0]      ist_tmax,
   output logic [TRI_W-1:0] ist_tri,
   input  logic             ist_done,
   input  logic             ist_isected,
   input  logic [31:0]      ist_t,
   input  logic [31:0]      ist_u,
   input  logic [31:0]      ist_v,
   output logic             res_valid,
   input  logic             res_ready,
   output logic             res_hit,
   output logic [31:0]      res_t,
   output logic [31:0]      res_u,
   output logic [31:0]      res_v,
   output logic [IDX_W-1:0] res_tri
);

   localparam int unsigned FW = 32;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_LOAD   = 3'd2,
      S_ISSUE  = 3'd3,
      S_WAIT   = 3'd4,
      S_RESULT = 3'd5
   } state_e;

   state_e           state;
   logic [IDX_W-1:0] idx;
   logic [IDX_W-1:0] remaining;
   logic [FW-1:0]    best_t;
   logic [FW-1:0]    best_u;
   logic [FW-1:0]    best_v;
   logic [IDX_W-1:0] best_tri;
   logic             hit;
`ifdef IST_SCHED_ANY_HIT_EN
   logic             any_hit_q;
`endif

   logic             take;
   logic             last;
   logic [FW-1:0]    nxt_t;
   logic [FW-1:0]    nxt_u;
   logic [FW-1:0]    nxt_v;
   logic [IDX_W-1:0] nxt_tri;
   logic             nxt_hit;
   logic [IDX_W-1:0] idx_inc;

   // Candidate best-hit values including a hit reported this cycle; the ist unit only reports improvements.
   always_comb begin
      take    = (state == S_WAIT) && ist_done && ist_isected;
      nxt_t   = take ? ist_t : best_t;
      nxt_u   = take ? ist_u : best_u;
      nxt_v   = take ? ist_v : best_v;
      nxt_tri = take ? idx : best_tri;
      nxt_hit = hit | take;
      idx_inc = idx + IDX_W'(1);
      last    = (remaining == IDX_W'(1));
`ifdef IST_SCHED_ANY_HIT_EN
      if (any_hit_q && ist_isected) last = 1'b1;
`endif
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= S_IDLE;
         req_ready    <= 1'b0;
         tri_rd_en    <= 1'b0;
         tri_addr     <= '0;
         ist_valid    <= 1'b0;
         ist_origin_x <= '0;
         ist_origin_y <= '0;
         ist_origin_z <= '0;
         ist_dir_x    <= '0;
         ist_dir_y    <= '0;
         ist_dir_z    <= '0;
         ist_tmax     <= '0;
         ist_tri      <= '0;
         res_valid    <= 1'b0;
         res_hit      <= 1'b0;
         res_t        <= '0;
         res_u        <= '0;
         res_v        <= '0;
         res_tri      <= '0;
         idx          <= '0;
         remaining    <= '0;
         best_t       <= '0;
         best_u       <= '0;
         best_v       <= '0;
         best_tri     <= '0;
         hit          <= 1'b0;
`ifdef IST_SCHED_ANY_HIT_EN
         any_hit_q    <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid && req_ready) begin
                  req_ready    <= 1'b0;
                  ist_origin_x <= origin_x;
                  ist_origin_y <= origin_y;
                  ist_origin_z <= origin_z;
                  ist_dir_x    <= dir_x;
                  ist_dir_y    <= dir_y;
                  ist_dir_z    <= dir_z;
                  best_t       <= tmax;
                  best_u       <= '0;
                  best_v       <= '0;
                  best_tri     <= '0;
                  hit          <= 1'b0;
                  idx          <= tri_first;
                  remaining    <= tri_count;
`ifdef IST_SCHED_ANY_HIT_EN
                  any_hit_q    <= any_hit;
`endif
                  if (tri_count == '0) begin
                     state     <= S_RESULT;
                     res_valid <= 1'b1;
                     res_hit   <= 1'b0;
                     res_t     <= tmax;
                     res_u     <= '0;
                     res_v     <= '0;
                     res_tri   <= '0;
                  end else begin
                     state     <= S_FETCH;
                     tri_rd_en <= 1'b1;
                     tri_addr  <= tri_first;
                  end
               end else begin
                  req_ready <= 1'b1;
               end
            end
            S_FETCH: begin
               tri_rd_en <= 1'b0;
               state     <= S_LOAD;
            end
            S_LOAD: begin
               ist_tri   <= tri_rdata;
               ist_tmax  <= best_t;
               ist_valid <= 1'b1;
               state     <= S_ISSUE;
            end
            S_ISSUE: begin
               ist_valid <= 1'b0;
               state     <= S_WAIT;
            end
            S_WAIT: begin
               if (ist_done) begin
                  best_t    <= nxt_t;
                  best_u    <= nxt_u;
                  best_v    <= nxt_v;
                  best_tri  <= nxt_tri;
                  hit       <= nxt_hit;
                  remaining <= remaining - IDX_W'(1);
                  idx       <= idx_inc;
                  if (last) begin
                     state     <= S_RESULT;
                     res_valid <= 1'b1;
                     res_hit   <= nxt_hit;
                     res_t     <= nxt_t;
                     res_u     <= nxt_hit ? nxt_u : '0;
                     res_v     <= nxt_hit ? nxt_v : '0;
                     res_tri   <= nxt_hit ? nxt_tri : '0;
                  end else begin
                     state     <= S_FETCH;
                     tri_rd_en <= 1'b1;
                     tri_addr  <= idx_inc;
                  end
               end
            end
            S_RESULT: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  req_ready <= 1'b1;
                  state     <= S_IDLE;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ist_sched.sv
// Directed bench for ist_sched: triangle RAM model plus a stub ist unit with fixed latency.
module tb_ist_sched;
   localparam int unsigned IDX_W = 16;
   localparam int unsigned TRI_W = 384;
   localparam int unsigned LAT   = 4;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   logic             req_valid = 1'b0;
   logic             req_ready;
   logic             any_hit = 1'b0;
   logic [31:0]      origin_x = '0, origin_y = '0, origin_z = '0;
   logic [31:0]      dir_x = '0, dir_y = '0, dir_z = '0, tmax = '0;
   logic [IDX_W-1:0] tri_first = '0, tri_count = '0;
   logic             tri_rd_en;
   logic [IDX_W-1:0] tri_addr;
   logic [TRI_W-1:0] tri_rdata = '0;
   logic             ist_valid;
   logic [31:0]      ist_origin_x, ist_origin_y, ist_origin_z;
   logic [31:0]      ist_dir_x, ist_dir_y, ist_dir_z, ist_tmax;
   logic [TRI_W-1:0] ist_tri;
   logic             ist_done, ist_isected;
   logic [31:0]      ist_t, ist_u, ist_v;
   logic             res_valid;
   logic             res_ready = 1'b0;
   logic             res_hit;
   logic [31:0]      res_t, res_u, res_v;
   logic [IDX_W-1:0] res_tri;

   ist_sched #(.IDX_W(IDX_W), .TRI_W(TRI_W)) dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready),
`ifdef IST_SCHED_ANY_HIT_EN
      .any_hit(any_hit),
`endif
      .origin_x(origin_x), .origin_y(origin_y), .origin_z(origin_z),
      .dir_x(dir_x), .dir_y(dir_y), .dir_z(dir_z), .tmax(tmax),
      .tri_first(tri_first), .tri_count(tri_count),
      .tri_rd_en(tri_rd_en), .tri_addr(tri_addr), .tri_rdata(tri_rdata),
      .ist_valid(ist_valid),
      .ist_origin_x(ist_origin_x), .ist_origin_y(ist_origin_y), .ist_origin_z(ist_origin_z),
      .ist_dir_x(ist_dir_x), .ist_dir_y(ist_dir_y), .ist_dir_z(ist_dir_z),
      .ist_tmax(ist_tmax), .ist_tri(ist_tri),
      .ist_done(ist_done), .ist_isected(ist_isected),
      .ist_t(ist_t), .ist_u(ist_u), .ist_v(ist_v),
      .res_valid(res_valid), .res_ready(res_ready), .res_hit(res_hit),
      .res_t(res_t), .res_u(res_u), .res_v(res_v), .res_tri(res_tri)
   );

   function automatic logic [TRI_W-1:0] tri_pat(input logic [IDX_W-1:0] a);
      logic [TRI_W-1:0] p;
      p = '0;
      for (int k = 0; k < 12; k++) p[k*32 +: 32] = {8'(k), 8'hA5, a};
      return p;
   endfunction

   // Triangle RAM: data appears one cycle after the read enable.
   always @(posedge clk) if (tri_rd_en) tri_rdata <= tri_pat(tri_addr);

   // Stub ist unit keyed by the low address bits of the issued triangle.
   logic        resp_hit [0:7];
   logic [31:0] resp_t   [0:7];
   int unsigned stub_cnt;
   logic [2:0]  stub_key;
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stub_cnt <= 0;
         stub_key <= '0;
      end else if (ist_valid) begin
         stub_cnt <= LAT;
         stub_key <= ist_tri[2:0];
      end else if (stub_cnt != 0) begin
         stub_cnt <= stub_cnt - 1;
      end
   end
   assign ist_done    = (stub_cnt == 1);
   assign ist_isected = ist_done && resp_hit[stub_key] && (resp_t[stub_key] < ist_tmax);
   assign ist_t       = resp_t[stub_key];
   assign ist_u       = 32'h0000_1000 | 32'(stub_key);
   assign ist_v       = 32'h0000_2000 | 32'(stub_key);

   // Activity log of read addresses and issued tmax values.
   int          n_rd = 0;
   int          n_iv = 0;
   logic [15:0] addr_q[$];
   logic [31:0] tmax_q[$];
   always @(posedge clk) begin
      if (reset_n) begin
         if (tri_rd_en) begin
            n_rd <= n_rd + 1;
            addr_q.push_back(tri_addr);
         end
         if (ist_valid) begin
            n_iv <= n_iv + 1;
            tmax_q.push_back(ist_tmax);
         end
      end
   end

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic clear_resp();
      for (int i = 0; i < 8; i++) begin
         resp_hit[i] = 1'b0;
         resp_t[i]   = 32'h0;
      end
   endtask

   task automatic send(input logic [31:0] tm, input logic [15:0] first, input logic [15:0] cnt);
      @(negedge clk);
      for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
      if (!req_ready) begin
         check("req_ready_wait", 64'(req_ready), 64'd1);
      end else begin
         tmax = tm;
         tri_first = first;
         tri_count = cnt;
         req_valid = 1'b1;
         @(posedge clk);
         #1 req_valid = 1'b0;
      end
   endtask

   // Cycle number (accept cycle = 1) at which res_valid is first seen.
   task automatic wait_res(output int cyc);
      cyc = 1;
      do begin
         @(negedge clk);
         cyc++;
      end while (!res_valid && cyc < 400);
      if (!res_valid) check("res_valid_timeout", 64'(res_valid), 64'd1);
   endtask

   task automatic take_res();
      res_ready = 1'b1;
      @(posedge clk);
      #1 res_ready = 1'b0;
      @(negedge clk);
      check("res_valid_drop", 64'(res_valid), 64'd0);
      check("req_ready_after", 64'(req_ready), 64'd1);
   endtask

   int cyc, brd, biv, bq;

   initial begin
      clear_resp();
      origin_x = 32'h0; origin_y = 32'h3dcccccd; origin_z = 32'h3f800000;
      dir_x = 32'h3ca3d70c; dir_y = 32'hbca3d70c; dir_z = 32'hbf800000;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_req_ready", 64'(req_ready), 64'd0);
      check("rst_rd_en", 64'(tri_rd_en), 64'd0);
      check("rst_ist_valid", 64'(ist_valid), 64'd0);
      check("rst_res_valid", 64'(res_valid), 64'd0);
      check("rst_res_t", 64'(res_t), 64'd0);
      check("rst_ist_tmax", 64'(ist_tmax), 64'd0);
      check("rst_ist_tri", 64'(ist_tri == '0), 64'd1);
      reset_n = 1'b1;
      @(negedge clk);
      check("req_ready_post_rst", 64'(req_ready), 64'd1);

      // Single triangle hit
      resp_hit[5] = 1'b1; resp_t[5] = 32'h3f7d70a4;
      brd = n_rd; biv = n_iv; bq = tmax_q.size();
      send(32'h7f7fffff, 16'd5, 16'd1);
      wait_res(cyc);
      check("t1_latency", 64'(cyc), 64'd9);
      check("t1_hit", 64'(res_hit), 64'd1);
      check("t1_t", 64'(res_t), 64'h3f7d70a4);
      check("t1_tri", 64'(res_tri), 64'd5);
      check("t1_u", 64'(res_u), 64'h1005);
      check("t1_v", 64'(res_v), 64'h2005);
      check("t1_ist_tri", 64'(ist_tri == tri_pat(16'd5)), 64'd1);
      check("t1_origin_y", 64'(ist_origin_y), 64'h3dcccccd);
      check("t1_dir_z", 64'(ist_dir_z), 64'hbf800000);
      check("t1_nrd", 64'(n_rd - brd), 64'd1);
      check("t1_niv", 64'(n_iv - biv), 64'd1);
      check("t1_tmax0", 64'(tmax_q[bq]), 64'h7f7fffff);
      take_res();

      // Empty range
      clear_resp();
      brd = n_rd; biv = n_iv;
      send(32'h40000000, 16'd3, 16'd0);
      wait_res(cyc);
      check("t0_latency", 64'(cyc), 64'd2);
      check("t0_hit", 64'(res_hit), 64'd0);
      check("t0_t", 64'(res_t), 64'h40000000);
      check("t0_tri", 64'(res_tri), 64'd0);
      check("t0_u", 64'(res_u), 64'd0);
      check("t0_nrd", 64'(n_rd - brd), 64'd0);
      check("t0_niv", 64'(n_iv - biv), 64'd0);
      take_res();

      // Four triangles, closest is the second; third is rejected by the shrunk tmax
      clear_resp();
      resp_hit[0] = 1'b1; resp_t[0] = 32'h40400000;
      resp_hit[1] = 1'b1; resp_t[1] = 32'h3f800000;
      resp_hit[2] = 1'b1; resp_t[2] = 32'h40000000;
      bq = tmax_q.size();
      send(32'h7f7fffff, 16'd8, 16'd4);
      wait_res(cyc);
      check("t4_latency", 64'(cyc), 64'd30);
      check("t4_hit", 64'(res_hit), 64'd1);
      check("t4_t", 64'(res_t), 64'h3f800000);
      check("t4_tri", 64'(res_tri), 64'd9);
      check("t4_u", 64'(res_u), 64'h1001);
      check("t4_tmax1", 64'(tmax_q[bq+1]), 64'h40400000);
      check("t4_tmax2", 64'(tmax_q[bq+2]), 64'h3f800000);
      check("t4_tmax3", 64'(tmax_q[bq+3]), 64'h3f800000);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("t4_hold_valid", 64'(res_valid), 64'd1);
         check("t4_hold_t", 64'(res_t), 64'h3f800000);
         check("t4_hold_tri", 64'(res_tri), 64'd9);
      end
      take_res();

      // Index wraps past the top of the address space
      clear_resp();
      resp_hit[7] = 1'b1; resp_t[7] = 32'h40a00000;
      bq = addr_q.size();
      send(32'h7f7fffff, 16'hFFFE, 16'd3);
      wait_res(cyc);
      check("tw_latency", 64'(cyc), 64'd23);
      check("tw_addr0", 64'(addr_q[bq]), 64'hFFFE);
      check("tw_addr1", 64'(addr_q[bq+1]), 64'hFFFF);
      check("tw_addr2", 64'(addr_q[bq+2]), 64'h0000);
      check("tw_tri", 64'(res_tri), 64'hFFFF);
      check("tw_t", 64'(res_t), 64'h40a00000);
      take_res();

      // Reset while waiting on the ist unit
      clear_resp();
      resp_hit[5] = 1'b1; resp_t[5] = 32'h3f7d70a4;
      send(32'h7f7fffff, 16'd4, 16'd2);
      for (int i = 0; i < 50 && !ist_valid; i++) @(negedge clk);
      check("tr_issue_seen", 64'(ist_valid), 64'd1);
      repeat (2) @(negedge clk);
      reset_n = 1'b0;
      #1;
      check("tr_ist_valid", 64'(ist_valid), 64'd0);
      check("tr_res_valid", 64'(res_valid), 64'd0);
      check("tr_req_ready", 64'(req_ready), 64'd0);
      check("tr_ist_tmax", 64'(ist_tmax), 64'd0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("tr_no_result", 64'(res_valid), 64'd0);
      end
      send(32'h7f7fffff, 16'd5, 16'd1);
      wait_res(cyc);
      check("tr_latency", 64'(cyc), 64'd9);
      check("tr_hit", 64'(res_hit), 64'd1);
      check("tr_t", 64'(res_t), 64'h3f7d70a4);
      check("tr_tri", 64'(res_tri), 64'd5);
      take_res();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1);
   end
endmodule
